// File: rtl/encoder_4_to_2_pkg.sv
// Shared types, code constants and the priority-pick helper
// for the registered, queued 4-to-2 encoder.
package encoder_4_to_2_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    // Later matches overwrite earlier ones, so scan order sets priority.
    function automatic logic [1:0] pick_code(
        input logic [3:0] req,
        input logic       prio_high
    );
        logic [1:0] code;
        code = CODE_D0;
        if (prio_high) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) code = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) code = 2'(i);
            end
        end
        return code;
    endfunction

    function automatic logic [3:0] code_onehot(
        input logic [1:0] code
    );
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (code)
            CODE_D0: oh = 4'b0001;
            CODE_D1: oh = 4'b0010;
            CODE_D2: oh = 4'b0100;
            CODE_D3: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/encoder_4_to_2_priority_pick_4.sv
// Combinational pick of the highest-priority pending request.
// onehot is zero when nothing is requested.
module priority_pick_4
    import encoder_4_to_2_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [3:0] req,
    output logic [1:0] code,
    output logic [3:0] onehot,
    output logic       any
);

    always_comb begin
        any    = |req;
        code   = pick_code(req, PRIORITY_HIGH);
        onehot = any ? code_onehot(code) : 4'b0000;
    end

endmodule

// File: rtl/encoder_4_to_2.sv
// Registered, queued 4-to-2 priority encoder with a valid/ready
// output handshake; requests pend in P until emitted.
module encoder_4_to_2
    import encoder_4_to_2_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic E,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic RDY,
    output logic A,
    output logic B,
    output logic V,
    output logic BUSY
);

    state_e     state_q, state_d;
    logic [3:0] p_q, p_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       v_q, v_d;

    logic [1:0] pick_code_w;
    logic [3:0] pick_oh;
    logic       pick_any;
    logic [3:0] clr;
    logic [3:0] req_in;
    logic       load;

    priority_pick_4 #(
        .PRIORITY_HIGH(PRIORITY_HIGH)
    ) u_pick (
        .req   (p_q),
        .code  (pick_code_w),
        .onehot(pick_oh),
        .any   (pick_any)
    );

    assign req_in = {D3, D2, D1, D0} & {4{E}};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        v_d     = v_q;
        load    = 1'b0;
        clr     = 4'b0000;
        unique case (state_q)
            ST_IDLE: load = pick_any;
            ST_HOLD: begin
                if (RDY) begin
                    load = pick_any;
                    if (!pick_any) begin
                        v_d     = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            {a_d, b_d} = pick_code_w;
            v_d        = 1'b1;
            state_d    = ST_HOLD;
            clr        = pick_oh;
        end
        // New requests win over the clear so level-held lines re-pend.
        p_d = (p_q & ~clr) | req_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= 4'b0000;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v_q     <= v_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign V    = v_q;
    assign BUSY = v_q | (|p_q);

endmodule
